// File: rtl/wb_pkg.sv
// Shared writeback definitions: result select, load func3 codes, ctrlWB layout.
// The ctrlWB bit indices are also used by the decode control unit.
package wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10,
      WB_IMM = 2'b11
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int CTRL_W        = 7;
   localparam int CTRL_REGWRITE = 6;
   localparam int CTRL_WBSEL_HI = 5;
   localparam int CTRL_WBSEL_LO = 4;
   localparam int CTRL_F3_HI    = 3;
   localparam int CTRL_F3_LO    = 1;
   localparam int CTRL_RSVD     = 0;

   typedef struct packed {
      logic       regWrite;
      wb_sel_e    wbSel;
      logic [2:0] func3;
   } wb_ctrl_t;

   // Takes ctrlWB[6:1]; the reserved bit never reaches the pipeline.
   function automatic wb_ctrl_t ctrl_decode(
      input logic [CTRL_REGWRITE-CTRL_F3_LO:0] c
   );
      wb_ctrl_t r;
      r.regWrite = c[CTRL_REGWRITE-CTRL_F3_LO];
      r.wbSel    = wb_sel_e'(c[CTRL_WBSEL_HI-CTRL_F3_LO:
                               CTRL_WBSEL_LO-CTRL_F3_LO]);
      r.func3    = c[CTRL_F3_HI-CTRL_F3_LO:0];
      return r;
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load extractor: picks byte/half/word from the raw memory word and extends it.
// Flags halfword and word accesses whose address is not naturally aligned.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_func3,
   input  logic [1:0]      i_off,
   input  logic [XLEN-1:0] i_word,
   output logic [XLEN-1:0] o_data,
   output logic            o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[7:0];
      unique case (i_off)
         2'd0: w_byte = i_word[7:0];
         2'd1: w_byte = i_word[15:8];
         2'd2: w_byte = i_word[23:16];
         2'd3: w_byte = i_word[31:24];
      endcase
   end

   // Halfword lane follows off[1] only, even for a misaligned address.
   assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_data       = '0;
      o_misaligned = 1'b0;
      case (i_func3)
         F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH: begin
            o_data       = {{(XLEN-16){w_half[15]}}, w_half};
            o_misaligned = i_off[0];
         end
         F3_LHU: begin
            o_data       = {{(XLEN-16){1'b0}}, w_half};
            o_misaligned = i_off[0];
         end
         F3_LW: begin
            o_data       = i_word;
            o_misaligned = (i_off != 2'b00);
         end
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select/align, regfile write, instret.
// Define WB_BYPASS_EN to add EX forwarding ports fed from the MEM/WB register.
module wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_valid,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic [6:0]       i_ctrlWB,
   input  logic [4:0]       i_rd,
   input  logic [XLEN-1:0]  i_aluResult,
   input  logic [XLEN-1:0]  i_memData,
   input  logic [XLEN-1:0]  i_pcPlus4,
   input  logic [XLEN-1:0]  i_imm,
   output logic             o_wrSig,
   output logic [4:0]       o_wrReg,
   output logic [XLEN-1:0]  o_wrData,
   output logic             o_misalign,
   output logic [CNT_W-1:0] o_instret
`ifdef WB_BYPASS_EN
   ,
   output logic             o_fwdValid,
   output logic [4:0]       o_fwdReg,
   output logic [XLEN-1:0]  o_fwdData
`endif
);

   wb_ctrl_t         r_ctrl;
   logic             r_valid;
   logic             r_done;
   logic [4:0]       r_rd;
   logic [XLEN-1:0]  r_alu;
   logic [XLEN-1:0]  r_mem;
   logic [XLEN-1:0]  r_pc4;
   logic [XLEN-1:0]  r_imm;
   logic [CNT_W-1:0] r_instret;

   logic [XLEN-1:0]  w_ldData;
   logic             w_alignMis;
   logic             w_mis;
   logic             w_commit;
   logic             w_unused;

   assign w_unused = i_ctrlWB[CTRL_RSVD];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_ctrl    <= '0;
         r_rd      <= '0;
         r_alu     <= '0;
         r_mem     <= '0;
         r_pc4     <= '0;
         r_imm     <= '0;
         r_instret <= '0;
      end else begin
         if (!i_stall) begin
            r_valid <= i_valid & ~i_flush;
            r_done  <= 1'b0;
            r_ctrl  <= ctrl_decode(i_ctrlWB[CTRL_REGWRITE:CTRL_F3_LO]);
            r_rd    <= i_rd;
            r_alu   <= i_aluResult;
            r_mem   <= i_memData;
            r_pc4   <= i_pcPlus4;
            r_imm   <= i_imm;
         end else if (w_commit) begin
            r_done <= 1'b1;
         end
         if (w_commit) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   wb_load_align #(.XLEN(XLEN)) u_align (
      .i_func3      (r_ctrl.func3),
      .i_off        (r_alu[1:0]),
      .i_word       (r_mem),
      .o_data       (w_ldData),
      .o_misaligned (w_alignMis)
   );

   // Only the first cycle of a held entry may write, flag or count.
   assign w_commit   = r_valid & ~r_done;
   assign w_mis      = (r_ctrl.wbSel == WB_MEM) & w_alignMis;
   assign o_wrSig    = w_commit & r_ctrl.regWrite &
                       (r_rd != 5'd0) & ~w_mis;
   assign o_misalign = w_commit & w_mis;
   assign o_wrReg    = r_rd;
   assign o_instret  = r_instret;

   always_comb begin
      o_wrData = r_alu;
      unique case (r_ctrl.wbSel)
         WB_ALU: o_wrData = r_alu;
         WB_MEM: o_wrData = w_ldData;
         WB_PC4: o_wrData = r_pc4;
         WB_IMM: o_wrData = r_imm;
      endcase
   end

`ifdef WB_BYPASS_EN
   // Held for the whole stall so EX keeps seeing the pending result.
   assign o_fwdValid = r_valid & r_ctrl.regWrite &
                       (r_rd != 5'd0) & ~w_mis;
   assign o_fwdReg   = r_rd;
   assign o_fwdData  = o_wrData;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with an expected-result queue.
// Set WB_BYPASS_EN identically for bench and RTL to cover the forwarding ports.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_flush = 1'b0;
   logic [6:0]  i_ctrlWB = '0;
   logic [4:0]  i_rd = '0;
   logic [31:0] i_alu = '0;
   logic [31:0] i_mem = '0;
   logic [31:0] i_pc4 = '0;
   logic [31:0] i_imm = '0;
   logic        o_wrSig;
   logic [4:0]  o_wrReg;
   logic [31:0] o_wrData;
   logic        o_misalign;
   logic [63:0] o_instret;
`ifdef WB_BYPASS_EN
   logic        o_fwdValid;
   logic [4:0]  o_fwdReg;
   logic [31:0] o_fwdData;
`endif

   typedef struct {
      logic        sig;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_cnt = '0;

   always #5 clk = ~clk;

   wb_stage dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_valid     (i_valid),
      .i_stall     (i_stall),
      .i_flush     (i_flush),
      .i_ctrlWB    (i_ctrlWB),
      .i_rd        (i_rd),
      .i_aluResult (i_alu),
      .i_memData   (i_mem),
      .i_pcPlus4   (i_pc4),
      .i_imm       (i_imm),
      .o_wrSig     (o_wrSig),
      .o_wrReg     (o_wrReg),
      .o_wrData    (o_wrData),
      .o_misalign  (o_misalign),
      .o_instret   (o_instret)
`ifdef WB_BYPASS_EN
      ,
      .o_fwdValid  (o_fwdValid),
      .o_fwdReg    (o_fwdReg),
      .o_fwdData   (o_fwdData)
`endif
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] mk(input logic rw,
                                     input logic [1:0] sel,
                                     input logic [2:0] f3);
      return {rw, sel, f3, 1'b0};
   endfunction

   function automatic exp_t model(input logic v, input logic fl,
                                  input logic [6:0] c,
                                  input logic [4:0] rd,
                                  input logic [31:0] alu,
                                  input logic [31:0] mem,
                                  input logic [31:0] pc4,
                                  input logic [31:0] imm);
      exp_t        e;
      logic [31:0] sb;
      logic [31:0] sh;
      logic [31:0] ld;
      logic        mis;
      sb  = mem >> (8 * int'(alu[1:0]));
      sh  = alu[1] ? (mem >> 16) : mem;
      ld  = 32'd0;
      mis = 1'b0;
      case (c[3:1])
         3'b000: ld = {{24{sb[7]}}, sb[7:0]};
         3'b100: ld = {24'd0, sb[7:0]};
         3'b001: begin
            ld  = {{16{sh[15]}}, sh[15:0]};
            mis = alu[0];
         end
         3'b101: begin
            ld  = {16'd0, sh[15:0]};
            mis = alu[0];
         end
         3'b010: begin
            ld  = mem;
            mis = (alu[1:0] != 2'b00);
         end
         default: ld = 32'd0;
      endcase
      case (c[5:4])
         2'b00: e.data = alu;
         2'b01: e.data = ld;
         2'b10: e.data = pc4;
         default: e.data = imm;
      endcase
      e.mis = v & ~fl & (c[5:4] == 2'b01) & mis;
      e.sig = v & ~fl & c[6] & (rd != 5'd0) &
              ~((c[5:4] == 2'b01) & mis);
      e.rd  = rd;
      return e;
   endfunction

   task automatic check_out(input string tag);
      exp_t e;
      e = q.pop_front();
      chk({tag, ".sig"}, 64'(o_wrSig), 64'(e.sig));
      chk({tag, ".reg"}, 64'(o_wrReg), 64'(e.rd));
      chk({tag, ".data"}, 64'(o_wrData), 64'(e.data));
      chk({tag, ".mis"}, 64'(o_misalign), 64'(e.mis));
   endtask

   task automatic drive(input logic v, input logic fl,
                        input logic [6:0] c, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem);
      @(negedge clk);
      i_stall  = 1'b0;
      i_valid  = v;
      i_flush  = fl;
      i_ctrlWB = c;
      i_rd     = rd;
      i_alu    = alu;
      i_mem    = mem;
      i_pc4    = alu + 32'h100;
      i_imm    = mem ^ 32'h5A5A_0000;
      q.push_back(model(v, fl, c, rd, alu, mem, i_pc4, i_imm));
      if (v & ~fl) exp_cnt = exp_cnt + 64'd1;
   endtask

   task automatic issue(input string tag,
                        input logic v, input logic fl,
                        input logic [6:0] c, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem);
      drive(v, fl, c, rd, alu, mem);
      @(posedge clk); #1;
      check_out(tag);
      @(negedge clk);
      i_valid = 1'b0;
      i_flush = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".cnt"}, o_instret, exp_cnt);
      chk({tag, ".idle"}, 64'({o_wrSig, o_misalign}), 64'd0);
   endtask

   task automatic stall_run(input string tag, input logic [6:0] c,
                            input logic [4:0] rd,
                            input logic [31:0] alu,
                            input logic [31:0] mem, input int n);
      exp_t e;
      drive(1'b1, 1'b0, c, rd, alu, mem);
      e = q[q.size()-1];
      @(posedge clk); #1;
      check_out({tag, ".c"});
      @(negedge clk);
      i_stall = 1'b1;
      i_valid = 1'b1;
      i_flush = 1'b1;
      i_rd    = ~rd;
      i_alu   = ~alu;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         chk({tag, ".ssig"}, 64'({o_wrSig, o_misalign}), 64'd0);
         chk({tag, ".sreg"}, 64'(o_wrReg), 64'(rd));
         chk({tag, ".sdata"}, 64'(o_wrData), 64'(e.data));
         chk({tag, ".scnt"}, o_instret, exp_cnt);
`ifdef WB_BYPASS_EN
         chk({tag, ".fwd"}, 64'(o_fwdValid), 64'(e.sig));
         chk({tag, ".fdat"}, 64'(o_fwdData), 64'(e.data));
`endif
      end
      @(negedge clk);
      i_stall = 1'b0;
      i_valid = 1'b0;
      i_flush = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".cnt"}, o_instret, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_valid  = 1'b1;
      i_ctrlWB = mk(1'b1, 2'b00, 3'b000);
      i_rd     = 5'd3;
      i_alu    = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.sig", 64'(o_wrSig), 64'd0);
      chk("rst.reg", 64'(o_wrReg), 64'd0);
      chk("rst.data", 64'(o_wrData), 64'd0);
      chk("rst.mis", 64'(o_misalign), 64'd0);
      chk("rst.cnt", o_instret, 64'd0);
      @(negedge clk);
      i_valid = 1'b0;
      rst_n   = 1'b1;

      issue("alu", 1, 0, mk(1, 2'b00, 3'b000), 5'd5,
            32'h0000_1234, 32'h0);
      issue("lb", 1, 0, mk(1, 2'b01, 3'b000), 5'd6,
            32'h0000_1003, 32'h80FF_0000);
      issue("lbu", 1, 0, mk(1, 2'b01, 3'b100), 5'd6,
            32'h0000_1003, 32'h80FF_0000);
      issue("lh", 1, 0, mk(1, 2'b01, 3'b001), 5'd8,
            32'h0000_2002, 32'h80FF_1234);
      issue("lhu", 1, 0, mk(1, 2'b01, 3'b101), 5'd8,
            32'h0000_2000, 32'h1234_9ABC);
      issue("lw", 1, 0, mk(1, 2'b01, 3'b010), 5'd9,
            32'h0000_3000, 32'hCAFE_F00D);
      issue("ldbad", 1, 0, mk(1, 2'b01, 3'b011), 5'd9,
            32'h0000_3000, 32'hCAFE_F00D);
      issue("pc4", 1, 0, mk(1, 2'b10, 3'b000), 5'd1,
            32'h0000_4000, 32'h0);
      issue("imm", 1, 0, mk(1, 2'b11, 3'b000) | 7'd1, 5'd2,
            32'h0, 32'h1234_5000);
      issue("lwmis", 1, 0, mk(1, 2'b01, 3'b010), 5'd10,
            32'h0000_5002, 32'h1111_2222);
      issue("lhmis", 1, 0, mk(1, 2'b01, 3'b001), 5'd11,
            32'h0000_5001, 32'h1111_8222);
      issue("nowr", 1, 0, mk(0, 2'b00, 3'b000), 5'd12,
            32'h0000_0077, 32'h0);
      issue("x0", 1, 0, mk(1, 2'b00, 3'b000), 5'd0,
            32'h0000_0042, 32'h0);
      issue("flush", 1, 1, mk(1, 2'b00, 3'b000), 5'd13,
            32'h0000_0099, 32'h0);
      issue("inval", 0, 0, mk(1, 2'b00, 3'b000), 5'd14,
            32'h0000_0055, 32'h0);

      stall_run("stall", mk(1, 2'b00, 3'b000), 5'd7,
                32'h0000_0777, 32'h0, 3);
      stall_run("stmis", mk(1, 2'b01, 3'b010), 5'd15,
                32'h0000_0601, 32'h0BAD_0BAD, 2);

      @(negedge clk);
      force dut.r_instret = '1;
      #1;
      release dut.r_instret;
      exp_cnt = '1;
      @(posedge clk); #1;
      chk("preload", o_instret, exp_cnt);
      issue("wrap", 1, 0, mk(1, 2'b00, 3'b000), 5'd4,
            32'h0000_0ABC, 32'h0);
      issue("post", 1, 0, mk(1, 2'b00, 3'b000), 5'd4,
            32'h0000_0ABD, 32'h0);

      @(negedge clk);
      i_valid  = 1'b1;
      i_ctrlWB = mk(1, 2'b00, 3'b000);
      i_rd     = 5'd9;
      i_alu    = 32'h0000_BEEF;
      @(posedge clk); #1;
      chk("mid.sig", 64'(o_wrSig), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.sig", 64'(o_wrSig), 64'd0);
      chk("arst.reg", 64'(o_wrReg), 64'd0);
      chk("arst.data", 64'(o_wrData), 64'd0);
      chk("arst.mis", 64'(o_misalign), 64'd0);
      chk("arst.cnt", o_instret, 64'd0);
      @(negedge clk);
      i_valid = 1'b0;
      rst_n   = 1'b1;
      @(posedge clk); #1;
      chk("arst.after", 64'(o_wrSig), 64'd0);
      chk("arst.cnt2", o_instret, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
